// File: rtl/ospi_flash_pkg.sv
// Shared opcodes, FSM states and status bit positions
// for the octal-SPI NOR flash command model.
package ospi_flash_pkg;

  localparam logic [7:0] OP_WREN = 8'h06;
  localparam logic [7:0] OP_WRDI = 8'h04;
  localparam logic [7:0] OP_RDSR = 8'h05;
  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [7:0] OP_PP   = 8'h02;
  localparam logic [7:0] OP_SE   = 8'h20;

  localparam int ST_WIP = 0;
  localparam int ST_WEL = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DUMMY,
    S_RDATA,
    S_WDATA,
    S_STATUS,
    S_IGNORE
  } state_t;

endpackage

// File: rtl/ospi_flash_page_buf.sv
// Page program buffer: PAGE_SIZE data bytes plus a
// valid bitmap, written one slot at a time.
module ospi_flash_page_buf #(
  parameter int PAGE_SIZE = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         we,
  input  logic [$clog2(PAGE_SIZE)-1:0] slot,
  input  logic [7:0]                   wdata,
  input  logic                         clr,
  output logic [PAGE_SIZE-1:0][7:0]    rd_data,
  output logic [PAGE_SIZE-1:0]         valid
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid <= '0;
    end else if (clr) begin
      valid <= '0;
    end else if (we) begin
      valid[slot] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (we) rd_data[slot] <= wdata;
  end

endmodule

// File: rtl/ospi_flash_cmd_model.sv
// Octal-SPI NOR flash command model (WREN/WRDI/RDSR/READ/PP/SE).
// Define OSPI_FLASH_BUSY_EN to model WIP busy timing after PP/SE.
module ospi_flash_cmd_model
  import ospi_flash_pkg::*;
#(
  parameter int ADDR_BYTES   = 3,
  parameter int ADDR_W       = 12,
  parameter int PAGE_SIZE    = 16,
  parameter int SECTOR_SIZE  = 256,
  parameter int DUMMY_CYCLES = 2,
  parameter int PROG_CYCLES  = 20,
  parameter int ERASE_CYCLES = 100
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ospi_cs_n,
  input  logic [7:0] ospi_io_in,
  output logic [7:0] ospi_io_out,
  output logic       ospi_io_oe
);

`ifdef OSPI_FLASH_BUSY_EN
  localparam bit BUSY = 1'b1;
`else
  localparam bit BUSY = 1'b0;
`endif

  localparam int PW = $clog2(PAGE_SIZE);
  localparam int SW = $clog2(SECTOR_SIZE);

  state_t state, state_d;
  logic [7:0] op, cnt, st;
  logic [ADDR_W-1:0] addr, pbase, sbase;
  logic wel, wip, wip_eff;
  logic [31:0] busy_cnt;
  logic wel_set, wel_clr, pp_go, se_go;
  logic buf_we, rd_ld, st_ld;
  logic [PAGE_SIZE-1:0][7:0] buf_data;
  logic [PAGE_SIZE-1:0] buf_valid;
  // Stored inverted so the all-zero power-up image reads as erased 0xFF.
  logic [7:0] mem_n [0:(1<<ADDR_W)-1];

  assign wip_eff = wip && (busy_cnt != 32'd1);
  assign pbase = {addr[ADDR_W-1:PW], PW'(0)};
  assign sbase = {addr[ADDR_W-1:SW], SW'(0)};

  always_comb begin
    st = '0;
    st[ST_WEL] = wel;
    st[ST_WIP] = wip_eff;
  end

  ospi_flash_page_buf #(.PAGE_SIZE(PAGE_SIZE)) u_buf (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (buf_we),
    .slot    (addr[PW-1:0]),
    .wdata   (ospi_io_in),
    .clr     (ospi_cs_n),
    .rd_data (buf_data),
    .valid   (buf_valid)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_d;
  end

  always_comb begin
    state_d = state;
    wel_set = 1'b0;
    wel_clr = 1'b0;
    pp_go   = 1'b0;
    se_go   = 1'b0;
    buf_we  = 1'b0;
    rd_ld   = 1'b0;
    st_ld   = 1'b0;
    if (ospi_cs_n) begin
      state_d = S_IDLE;
      pp_go = (state == S_WDATA) && (op == OP_PP)
              && wel && (|buf_valid);
      se_go = (state == S_WDATA) && (op == OP_SE) && wel;
    end else begin
      unique case (state)
        S_IDLE: begin
          state_d = S_IGNORE;
          priority case (1'b1)
            wip_eff && (ospi_io_in != OP_RDSR): ;
            ospi_io_in == OP_WREN: wel_set = 1'b1;
            ospi_io_in == OP_WRDI: wel_clr = 1'b1;
            ospi_io_in == OP_RDSR: begin
              st_ld   = 1'b1;
              state_d = S_STATUS;
            end
            ospi_io_in inside {OP_READ, OP_PP, OP_SE}:
              state_d = S_ADDR;
            default: ;
          endcase
        end
        S_ADDR: begin
          if (cnt == 8'(ADDR_BYTES - 1))
            state_d = (op == OP_READ) ? S_DUMMY : S_WDATA;
        end
        S_DUMMY: begin
          if (cnt == 8'(DUMMY_CYCLES - 1)) begin
            rd_ld   = 1'b1;
            state_d = S_RDATA;
          end
        end
        S_RDATA:  rd_ld = 1'b1;
        S_STATUS: st_ld = 1'b1;
        S_WDATA: begin
          // SE must end right after its address; any data byte voids it.
          if (op == OP_PP) buf_we = 1'b1;
          else             state_d = S_IGNORE;
        end
        S_IGNORE: ;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op          <= '0;
      cnt         <= '0;
      addr        <= '0;
      wel         <= 1'b0;
      wip         <= 1'b0;
      busy_cnt    <= '0;
      ospi_io_out <= 8'h00;
      ospi_io_oe  <= 1'b0;
    end else begin
      cnt <= (state_d == state) ? cnt + 8'd1 : 8'd0;
      if (state == S_IDLE) op <= ospi_io_in;

      if (state == S_ADDR && !ospi_cs_n)
        addr <= ADDR_W'({addr, ospi_io_in});
      else if (rd_ld)
        addr <= addr + 1'b1;
      else if (buf_we)
        addr[PW-1:0] <= addr[PW-1:0] + 1'b1;

      if (pp_go || se_go) wel <= 1'b0;
      else if (wel_set)   wel <= 1'b1;
      else if (wel_clr)   wel <= 1'b0;

      if (BUSY && pp_go) begin
        wip      <= 1'b1;
        busy_cnt <= 32'(PROG_CYCLES);
      end else if (BUSY && se_go) begin
        wip      <= 1'b1;
        busy_cnt <= 32'(ERASE_CYCLES);
      end else if (wip) begin
        busy_cnt <= busy_cnt - 32'd1;
        if (busy_cnt == 32'd1) wip <= 1'b0;
      end

      if (rd_ld) begin
        ospi_io_out <= ~mem_n[addr];
        ospi_io_oe  <= 1'b1;
      end else if (st_ld) begin
        ospi_io_out <= st;
        ospi_io_oe  <= 1'b1;
      end else if (ospi_cs_n) begin
        ospi_io_out <= 8'h00;
        ospi_io_oe  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < PAGE_SIZE; i++) begin
      if (pp_go && buf_valid[i])
        mem_n[pbase | ADDR_W'(i)] <=
          mem_n[pbase | ADDR_W'(i)] | ~buf_data[i];
    end
    if (se_go) begin
      for (int i = 0; i < SECTOR_SIZE; i++)
        mem_n[sbase | ADDR_W'(i)] <= 8'h00;
    end
  end

endmodule

// File: tb/tb_ospi_flash_cmd_model.sv
// Self-checking bench for ospi_flash_cmd_model against a
// byte-array reference model of the flash command set.
module tb_ospi_flash_cmd_model;

  localparam int AB = 3;
  localparam int AW = 12;
  localparam int PS = 16;
  localparam int SS = 256;
  localparam int DC = 2;
  localparam int PC = 20;
  localparam int EC = 100;
  localparam int DEPTH = 1 << AW;
`ifdef OSPI_FLASH_BUSY_EN
  localparam bit BUSY = 1'b1;
`else
  localparam bit BUSY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic       ospi_cs_n;
  logic [7:0] ospi_io_in;
  logic [7:0] ospi_io_out;
  logic       ospi_io_oe;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mm [0:DEPTH-1];
  bit          m_wel;
  int unsigned cyc_no, t0, dur;

  ospi_flash_cmd_model #(
    .ADDR_BYTES(AB), .ADDR_W(AW), .PAGE_SIZE(PS),
    .SECTOR_SIZE(SS), .DUMMY_CYCLES(DC),
    .PROG_CYCLES(PC), .ERASE_CYCLES(EC)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .ospi_cs_n   (ospi_cs_n),
    .ospi_io_in  (ospi_io_in),
    .ospi_io_out (ospi_io_out),
    .ospi_io_oe  (ospi_io_oe)
  );

  always #5 clk = ~clk;

  function automatic bit m_wip();
    return (cyc_no - t0) < dur;
  endfunction

  function automatic logic [7:0] m_st();
    return {6'b0, m_wel, m_wip()};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic cs, input logic [7:0] d);
    ospi_cs_n  = cs;
    ospi_io_in = d;
    @(posedge clk);
    cyc_no++;
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b1, 8'h00);
  endtask

  task automatic send_addr(input logic [23:0] a);
    for (int i = AB - 1; i >= 0; i--) cyc(1'b0, 8'(a >> (8 * i)));
  endtask

  task automatic wcmd(input logic [7:0] op);
    cyc(1'b0, op);
    if (!m_wip()) m_wel = (op == 8'h06);
    cyc(1'b1, 8'h00);
  endtask

  task automatic rdsr(input int n);
    cyc(1'b0, 8'h05);
    for (int i = 0; i < n; i++) begin
      chk("rdsr_oe", 8'(ospi_io_oe), 8'h01);
      chk("rdsr", ospi_io_out, m_st());
      cyc(1'b0, 8'($urandom));
    end
    cyc(1'b1, 8'h00);
    chk("rdsr_end_oe", 8'(ospi_io_oe), 8'h00);
  endtask

  task automatic wait_idle();
    cyc(1'b0, 8'h05);
    for (int i = 0; i < 200 && m_wip(); i++) begin
      chk("poll", ospi_io_out, m_st());
      cyc(1'b0, 8'h05);
    end
    chk("poll_done", ospi_io_out, m_st());
    cyc(1'b1, 8'h00);
  endtask

  task automatic rd(input logic [23:0] a, input int n,
                    output logic [7:0] first);
    bit bsy;
    logic [AW-1:0] ia;
    first = 8'hxx;
    ia = a[AW-1:0];
    cyc(1'b0, 8'h03);
    bsy = m_wip();
    send_addr(a);
    chk("rd_addr_oe", 8'(ospi_io_oe), 8'h00);
    repeat (DC) cyc(1'b0, 8'($urandom));
    if (bsy) begin
      chk("rd_busy_oe", 8'(ospi_io_oe), 8'h00);
    end else begin
      first = ospi_io_out;
      for (int i = 0; i < n; i++) begin
        chk("rd_oe", 8'(ospi_io_oe), 8'h01);
        chk("rd", ospi_io_out, mm[ia]);
        ia++;
        cyc(1'b0, 8'($urandom));
      end
    end
    cyc(1'b1, 8'h00);
    chk("rd_end_oe", 8'(ospi_io_oe), 8'h00);
  endtask

  task automatic pp(input logic [23:0] a, input logic [7:0] q[$]);
    bit bsy;
    logic [7:0] b [PS];
    bit v [PS];
    int ai, s, base;
    cyc(1'b0, 8'h02);
    bsy = m_wip();
    send_addr(a);
    foreach (q[i]) cyc(1'b0, q[i]);
    cyc(1'b1, 8'h00);
    chk("pp_oe", 8'(ospi_io_oe), 8'h00);
    if (!bsy && m_wel && q.size() > 0) begin
      ai = int'(a[AW-1:0]);
      base = ai - (ai % PS);
      foreach (v[i]) v[i] = 1'b0;
      foreach (q[i]) begin
        s = (ai + i) % PS;
        b[s] = q[i];
        v[s] = 1'b1;
      end
      for (int i = 0; i < PS; i++)
        if (v[i]) mm[base + i] = mm[base + i] & b[i];
      m_wel = 1'b0;
      if (BUSY) begin t0 = cyc_no; dur = PC; end
    end
  endtask

  task automatic se(input logic [23:0] a, input bit extra);
    bit bsy;
    int base;
    cyc(1'b0, 8'h20);
    bsy = m_wip();
    send_addr(a);
    if (extra) cyc(1'b0, 8'($urandom));
    cyc(1'b1, 8'h00);
    if (!bsy && m_wel && !extra) begin
      base = int'(a[AW-1:0]) - (int'(a[AW-1:0]) % SS);
      for (int i = 0; i < SS; i++) mm[base + i] = 8'hFF;
      m_wel = 1'b0;
      if (BUSY) begin t0 = cyc_no; dur = EC; end
    end
  endtask

  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1;
    chk("rst_async_oe", 8'(ospi_io_oe), 8'h00);
    chk("rst_async_out", ospi_io_out, 8'h00);
    m_wel = 1'b0;
    dur = 0;
    ospi_cs_n = 1'b1;
    @(posedge clk);
    cyc_no++;
    #1 reset_n = 1'b1;
    idle(1);
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] empty_q[$];
    logic [7:0] first;
    reset_n = 1'b0;
    ospi_cs_n = 1'b1;
    ospi_io_in = 8'h00;
    m_wel = 1'b0;
    t0 = 0;
    dur = 0;
    cyc_no = 0;
    foreach (mm[i]) mm[i] = 8'hFF;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_oe", 8'(ospi_io_oe), 8'h00);
    chk("reset_out", ospi_io_out, 8'h00);
    reset_n = 1'b1;
    idle(2);

    rdsr(3);
    wcmd(8'h06);
    rdsr(2);

    rd(24'h000010, 4, first);
    chk("fresh_ff", first, 8'hFF);

    wcmd(8'h06);
    q = '{8'hA5, 8'h3C, 8'h0F};
    pp(24'h00000E, q);
    rdsr(25);
    wait_idle();
    rd(24'h000000, 1, first);
    chk("pp_wrap_000", first, 8'h0F);
    rd(24'h00000E, 2, first);
    chk("pp_00e", first, 8'hA5);

    wcmd(8'h06);
    q = '{8'hF0};
    pp(24'h00000F, q);
    wait_idle();
    rd(24'h00000F, 1, first);
    chk("pp_and", first, 8'h30);
    q = '{8'h00};
    pp(24'h00000F, q);
    wait_idle();
    rd(24'h00000F, 1, first);
    chk("pp_no_wel", first, 8'h30);

    wcmd(8'h06);
    q = '{8'h5A};
    pp(24'h0000FF, q);
    wait_idle();
    wcmd(8'h06);
    q = '{8'h11, 8'h22};
    pp(24'h0001F0, q);
    wcmd(8'h06);
    se(24'h000123, 1'b0);
    rd(24'h0001F0, 2, first);
    wait_idle();
    wcmd(8'h06);
    se(24'h000123, 1'b0);
    rdsr(3);
    wait_idle();
    rd(24'h0000F0, 288, first);
    rd(24'h0000FF, 1, first);
    chk("se_keep_0ff", first, 8'h5A);
    rd(24'h0001F0, 1, first);
    chk("se_erased", first, 8'hFF);

    wcmd(8'h06);
    cyc(1'b0, 8'h02);
    cyc(1'b0, 8'h00);
    cyc(1'b0, 8'h00);
    cyc(1'b1, 8'h00);
    chk("abort_oe", 8'(ospi_io_oe), 8'h00);
    rdsr(1);
    se(24'h000000, 1'b1);
    rdsr(1);
    pp(24'h000020, empty_q);
    rdsr(1);

    cyc(1'b0, 8'h03);
    send_addr(24'h000010);
    repeat (DC) cyc(1'b0, 8'h00);
    cyc(1'b0, 8'h00);
    do_reset();
    rdsr(2);

    wcmd(8'h06);
    q = '{8'hC3};
    pp(24'h000050, q);
    do_reset();
    rdsr(1);
    rd(24'h000050, 1, first);
    chk("rst_busy_kept", first, 8'hC3);

    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 6))
        0: wcmd(8'h06);
        1: wcmd(8'h04);
        2: begin
          q.delete();
          repeat ($urandom_range(1, 20)) q.push_back(8'($urandom));
          if ($urandom_range(0, 3) != 0) wcmd(8'h06);
          pp(24'($urandom), q);
        end
        3: begin
          if ($urandom_range(0, 1) != 0) wcmd(8'h06);
          se(24'($urandom), $urandom_range(0, 3) == 0);
        end
        4: rd(24'($urandom), $urandom_range(1, 8), first);
        5: rdsr($urandom_range(1, 4));
        default: wait_idle();
      endcase
    end

    wait_idle();
    rd(24'h000000, DEPTH, first);
    rd(24'h000FFE, 4, first);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/ospi_flash_cmd_model.md
# ospi_flash_cmd_model

Parametrised octal-SPI NOR flash behavioural model with a real command protocol. It decodes an opcode / address / dummy / data sequence on an 8-bit octal bus and implements a write-enable latch and a status register. Page programs are buffered and commit with flash AND semantics; sector erase is also supported, with optional busy timing. It sits under the cocotbext-ospi benches as the device-under-test target for OSPI controller and driver verification, replacing the per-cycle strobe-driven flash stub.

## Interface
- ADDR_BYTES, 3: address bytes per command, MSB first; array depth = 2^(8*ADDR_BYTES) is capped by ADDR_W.
- ADDR_W, 12: implemented address bits; the upper address bits are ignored.
- PAGE_SIZE, 16: program page in bytes, power of two.
- SECTOR_SIZE, 256: erase granule in bytes, power of two, multiple of PAGE_SIZE.
- DUMMY_CYCLES, 2: READ dummy cycles, ≥1.
- PROG_CYCLES, 20: program busy time in clk cycles, ≥1.
- ERASE_CYCLES, 100: erase busy time in clk cycles, ≥1.
- clk  in  1  interface clock; one octal SDR transfer per cycle while selected.
- reset_n  in  1  asynchronous, active-low reset.
- ospi_cs_n  in  1  chip select, active low.
- ospi_io_in  in  8  bus sampled on rising clk.
- ospi_io_out  out  8  registered read/status data.
- ospi_io_oe  out  1  registered output enable. The top level builds the tristate from it.

## Operation
- The transfer counter k = 0 on the first clk edge with ospi_cs_n low.
- k=0 is the opcode byte:
  - 0x06 WREN: sets WEL.
  - 0x04 WRDI: clears WEL.
  - 0x05 RDSR: status stream.
  - 0x03 READ.
  - 0x02 PP: page program.
  - 0x20 SE: sector erase.
  - Any other opcode goes to IGNORE until ospi_cs_n rises.
- WREN and WRDI take effect at the k=0 edge.
- Status byte = {6'b0, WEL, WIP}.
- While WIP=1, only RDSR is honoured. Every other opcode goes to IGNORE, and WEL is unchanged.
- FSM states: IDLE, ADDR, DUMMY, RDATA, WDATA, STATUS, IGNORE.
  - Any ospi_cs_n high returns the FSM to IDLE on that edge.
- READ: ADDR_BYTES address bytes, then DUMMY_CYCLES dummy cycles, then sequential bytes.
  - The address increments by 1 per byte and wraps from 2^ADDR_W−1 to 0.
- PP: after the address, each byte is written into page buffer slot (addr + n) mod PAGE_SIZE, and that slot's valid bit is set.
  - Writing a slot twice keeps the last byte.
- Commit happens on ospi_cs_n rise, and only if WEL=1 and at least one complete data byte was taken.
  - Each valid slot is committed as mem[page_base + slot] &= buffer[slot].
  - Commit then sets WIP, clears WEL and clears all valid bits.
- SE: commits only if exactly ADDR_BYTES address bytes were received and no extra byte followed, and WEL=1.
  - The sector containing the address is filled with 0xFF; WIP is set and WEL cleared.
- A PP or SE without WEL=1 has no effect.
- reset_n low: FSM goes to IDLE; WEL, WIP, the busy counter and the valid bits are cleared.
  - ospi_io_out = 8'h00 and ospi_io_oe = 0.
  - The array is not reset. It is initialised to 0xFF at time zero only.
  - A reset during busy aborts the pending operation, but array writes already applied stay.

## Timing
- ospi_io_oe rises on the edge ending k = ADDR_BYTES+DUMMY_CYCLES for READ, and on the edge ending k=0 for RDSR.
  - It falls on the edge where ospi_cs_n is sampled high.
- READ data byte n is valid during cycle ADDR_BYTES+DUMMY_CYCLES+1+n.
- RDSR re-samples status every cycle, so WIP clearing is visible on the next byte.
- The array update happens in one cycle, on the ospi_cs_n rise edge. WIP reads 1 from the next cycle.
- WIP stays 1 for PROG_CYCLES or ERASE_CYCLES cycles, then clears.
- Simultaneous WIP clearing and a new opcode at k=0: the opcode sees WIP=0.

## Configuration
- OSPI_FLASH_BUSY_EN defined: WIP timing as above.
- OSPI_FLASH_BUSY_EN undefined: WIP is never set; PP and SE complete in the commit cycle, and the next command is accepted immediately.

## Structure
- Package ospi_flash_pkg holds:
  - the opcode localparams;
  - the FSM state enum;
  - the status bit indices.
- Sub-module ospi_flash_page_buf: PAGE_SIZE×8 data plus a valid bitmap, with write-slot, clear-all and per-slot read ports.

## Test plan
- Reset, then RDSR → ospi_io_out = 0x00 from cycle 1. Then WREN, then RDSR → 0x02.
- READ at 0x010 on a fresh array → 0xFF bytes from cycle 6 (ADDR_BYTES=3, DUMMY_CYCLES=2).
- WREN, PP at 0x00E with data A5,3C,0F → page-wrapped writes to 0x00E, 0x00F, 0x000. RDSR shows 0x01 for 20 cycles, then 0x00. READ at 0x000 → 0x0F.
- PP 0xF0 onto a byte holding 0x3C → reads 0x30 (AND semantics). PP with no preceding WREN → unchanged.
- SE at 0x123 during WIP → ignored. After WIP clears: WREN, SE → 0x100–0x1FF read 0xFF, and 0x0FF is unchanged.
- Deassert ospi_cs_n after 2 of 3 address bytes of a PP, or assert reset_n low mid-read → no array change, ospi_io_oe=0 next cycle, FSM in IDLE.
